// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, defaults, widths.
// No logic of its own; consumed by the loader top, its word packer and its interface.
// Optional checksum state exists only when IMEM_LOADER_CSUM_EN is defined.
package imem_pkg;

    localparam int               ADDR_W_DEF    = 12;
    localparam logic [11:0]      BASE_ADDR_DEF = 12'h000;
    localparam int               MAX_WORDS_DEF = 1024;
    localparam int               WORD_W        = 32;
    localparam int               BYTE_W        = 8;
    localparam int               LEN_W         = 16;
    localparam int               CNT_W         = 11;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
`ifdef IMEM_LOADER_CSUM_EN
        ,
        S_CSUM   = 3'd4
`endif
    } state_t;

    // States in which the loader is willing to take a byte from the host link.
    function automatic logic takes_bytes(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            S_LEN_HI, S_LEN_LO, S_DATA: r = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM:                     r = 1'b1;
`endif
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream (valid/ready) plus the instruction-RAM synchronous write port.
// slave = loader side (takes bytes, drives RAM writes); master = host/RAM side.
// in_ready is the only backpressure; the RAM write port never stalls.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_word_packer.sv
// Shifts accepted bytes MSB-first into a 32-bit word and counts bytes within the word.
// Word is valid the cycle after its 4th byte is shifted in; clear drops a partial word.
// No backpressure of its own; the caller decides when a byte is shifted.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_dat,
    output logic [WORD_W-1:0] word_dat,
    output logic [1:0]        byte_idx
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        idx_q,  idx_d;

    // Big-endian packing: earlier bytes end up in the upper bits; index wraps after byte 3.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_en) begin
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_dat};
            idx_d  = idx_q + 2'd1;
        end
    end

    // Word and byte-index state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_dat = word_q;
    assign byte_idx = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream as 32-bit big-endian words into the instruction RAM.
// One RAM write cycle after each 4th payload byte; in_ready drops for that write cycle.
// in_ready is registered; bytes are held off during writes and after DONE/ERR. Optional checksum: IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int                MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t S_AFTER_PAYLOAD = S_CSUM;
`else
    localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

    state_t             state_q,    state_d;
    logic [LEN_W-1:0]   len_q,      len_d;
    logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_en_q,    wr_en_d;
    logic               done_q,     done_d;
    logic               error_q,    error_d;
    logic               cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [BYTE_W-1:0]  csum_q,     csum_d;
`endif

    logic               accept;
    logic               shift_en;
    logic [LEN_W-1:0]   len_full;
    logic [LEN_W-1:0]   words_after;
    logic [1:0]         byte_idx;
    logic [WORD_W-1:0]  packed_word;

    // A byte transfers only on valid && ready; start takes priority and discards it.
    assign accept      = bus.in_valid && in_ready_q && !start;
    assign shift_en    = accept && (state_q == S_DATA);
    assign len_full    = {len_q[LEN_W-1:BYTE_W], bus.in_data};
    assign words_after = {{(LEN_W-CNT_W){1'b0}}, word_cnt_q} + LEN_W'(1);

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .shift_en (shift_en),
        .byte_dat (bus.in_data),
        .word_dat (packed_word),
        .byte_idx (byte_idx)
    );

    // Next-state, address/count and checksum; registered outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_addr_d  = wr_addr_q;
        word_cnt_d = word_cnt_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d     = csum_q;
`endif
        if (start) begin
            state_d    = S_LEN_HI;
            len_d      = '0;
            wr_addr_d  = BASE_ADDR;
            word_cnt_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_d     = '0;
`endif
        end else begin
            case (state_q)
                S_LEN_HI: begin
                    if (accept) begin
                        len_d[LEN_W-1:BYTE_W] = bus.in_data;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_d = bus.in_data;
`endif
                        state_d = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_d = len_full;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_d = csum_q + bus.in_data;
`endif
                        if (len_full == '0) begin
                            state_d = S_AFTER_PAYLOAD;
                        end else if (len_full > MAX_LEN) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                        csum_d = csum_q + bus.in_data;
`endif
                        // The packer shifts this byte in on the same edge; 4th byte completes a word.
                        if (byte_idx == 2'd3) begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // Write happens this cycle; advance to the next word slot afterwards.
                    wr_addr_d  = wr_addr_q + WORD_STEP;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    state_d    = (words_after < len_q) ? S_DATA : S_AFTER_PAYLOAD;
                end
`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ERR;
            endcase
        end

        in_ready_d = takes_bytes(state_d);
        wr_en_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    // Loader FSM with its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN_HI;
            len_q      <= '0;
            wr_addr_q  <= BASE_ADDR;
            word_cnt_q <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_addr_q  <= wr_addr_d;
            word_cnt_q <= word_cnt_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = packed_word;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frame cases, hand-written restart/reset/checksum sequences,
// and random frames, all checked against a frame-level model of the expected RAM writes.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_imem_loader;

    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cpu_hold, done, error;
    logic [10:0] word_cnt;

    imem_loader_if #(.ADDR_W(12)) bus ();

    imem_loader #(
        .ADDR_W    (12),
        .BASE_ADDR (12'h000),
        .MAX_WORDS (MAXW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string nm;
        int    n;
        int    mode;
        bit    gaps;
        bit    e_done;
        bit    e_err;
        int    e_cnt;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         errors = 0;
    int         checks = 0;
    int         rdy_viol = 0;
    bit         send_ok;
    vec_t       vecs[7];
    logic [7:0] basic_pat[8];

    // Capture every RAM write and flag any write cycle where a byte could be taken.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got_q.push_back('{bus.wr_addr, bus.wr_data});
            if (bus.in_ready !== 1'b0) rdy_viol++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 64 && !got; t++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                got = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            send_ok = 1'b0;
            $display("FAIL byte_accept: byte 0x%0h not taken within 64 cycles", b);
        end
    endtask

    task automatic send_frame(input bit gaps);
        send_ok = 1'b1;
        for (int i = 0; i < frame.size() && send_ok; i++) begin
            if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(frame[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Header, payload (fixed pattern / random / zeros) and, with checksum enabled, the sum byte.
    task automatic build_frame(input int n, input int mode, input bit bad_csum);
        logic [7:0] sum;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        if (n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) begin
                case (mode)
                    0:       b = basic_pat[i % 8];
                    1:       b = 8'($urandom);
                    default: b = 8'h00;
                endcase
                frame.push_back(b);
            end
            sum = 8'(bad_csum);
            for (int i = 0; i < frame.size(); i++) sum = sum + frame[i];
`ifdef IMEM_LOADER_CSUM_EN
            frame.push_back(sum);
`endif
        end
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_cpu_hold"}, cpu_hold, 1);
        chk({p, "_in_ready"}, bus.in_ready, 0);
        chk({p, "_wr_en"}, bus.wr_en, 0);
        chk({p, "_wr_addr"}, bus.wr_addr, 0);
        chk({p, "_wr_data"}, bus.wr_data, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_error"}, error, 0);
        chk({p, "_word_cnt"}, word_cnt, 0);
    endtask

    // Sends the current frame and checks status and writes; expected writes come from the frame itself.
    task automatic load_and_check(input string nm, input bit gaps, input bit use_tab,
                                  input bit t_done, input bit t_err, input int t_cnt);
        int n, m_cnt, waited, nchk;
        bit m_err, e_done, e_err;
        int e_cnt;
        logic [7:0] sum;
        wr_t w;
        n = int'({frame[0], frame[1]});
        exp_q.delete();
        m_err = 1'b0;
        m_cnt = 0;
        if (n > MAXW) begin
            m_err = 1'b1;
        end else begin
            m_cnt = n;
            for (int i = 0; i < n; i++) begin
                w.addr = 12'(4 * i);
                w.data = {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]};
                exp_q.push_back(w);
            end
`ifdef IMEM_LOADER_CSUM_EN
            sum = 8'h00;
            for (int i = 0; i < frame.size() - 1; i++) sum = sum + frame[i];
            if (sum != frame[frame.size()-1]) m_err = 1'b1;
`endif
        end
        e_done = use_tab ? t_done : !m_err;
        e_err  = use_tab ? t_err  : m_err;
        e_cnt  = use_tab ? t_cnt  : m_cnt;

        got_q.delete();
        send_frame(gaps);
        waited = 0;
        while (!(done === 1'b1 || error === 1'b1) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
`ifndef IMEM_LOADER_CSUM_EN
        if (n == 0) chk({nm, "_n0_done_latency"}, waited, 0);
`endif
        chk({nm, "_done"}, done, e_done);
        chk({nm, "_error"}, error, e_err);
        chk({nm, "_cpu_hold"}, cpu_hold, !e_done);
        chk({nm, "_word_cnt"}, word_cnt, e_cnt);
        chk({nm, "_in_ready_idle"}, bus.in_ready, 0);
        chk({nm, "_num_writes"}, got_q.size(), exp_q.size());
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) begin
            chk({nm, "_wr_addr"}, got_q[i].addr, exp_q[i].addr);
            chk({nm, "_wr_data"}, got_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bit gaps, bad;

        basic_pat = '{8'h27, 8'hBD, 8'hFF, 8'hF8, 8'hAF, 8'hBE, 8'h00, 8'h00};
        vecs[0] = '{"basic",   2,    0, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{"gaps",    2,    0, 1'b1, 1'b1, 1'b0, 2};
        vecs[2] = '{"n0",      0,    2, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{"n1025",   1025, 1, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{"n1024",   1024, 1, 1'b0, 1'b1, 1'b0, 1024};
        vecs[5] = '{"n256gap", 256,  1, 1'b1, 1'b1, 1'b0, 256};
        vecs[6] = '{"n1gap",   1,    2, 1'b1, 1'b1, 1'b0, 1};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            build_frame(vecs[v].n, vecs[v].mode, 1'b0);
            pulse_start();
            load_and_check(vecs[v].nm, vecs[v].gaps, 1'b1,
                           vecs[v].e_done, vecs[v].e_err, vecs[v].e_cnt);
        end

        // Restart after 6 payload bytes of a 3-word frame; start coincides with an offered byte.
        pulse_start();
        got_q.delete();
        frame = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(1'b0);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_word_cnt", word_cnt, 0);
        chk("restart_cpu_hold", cpu_hold, 1);
        chk("restart_wr_addr", bus.wr_addr, 0);
        chk("restart_wr_en", bus.wr_en, 0);
        chk("restart_num_writes", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            chk("restart_first_addr", got_q[0].addr, 12'h000);
            chk("restart_first_data", got_q[0].data, 32'h11223344);
        end
        frame = {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
        frame.push_back(8'h01);
`endif
        load_and_check("restart_reload", 1'b0, 1'b1, 1'b1, 1'b0, 1);

        // Asynchronous reset while a write is on the port.
        pulse_start();
        frame = {8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_frame(1'b0);
        chk("rst_mid_write_seen", bus.wr_en, 1);
        #1 rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOADER_CSUM_EN
        frame.push_back(8'hAB);
`endif
        load_and_check("after_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1);

`ifdef IMEM_LOADER_CSUM_EN
        pulse_start();
        frame = {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        load_and_check("csum_ok", 1'b0, 1'b1, 1'b1, 1'b0, 1);
        pulse_start();
        frame = {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        load_and_check("csum_bad", 1'b0, 1'b1, 1'b0, 1'b1, 1);
`endif

        // Random frames, occasionally oversized, occasionally with a wrong checksum.
        for (int r = 0; r < 8; r++) begin
            n    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1025, 65535))
                                               : int'($urandom_range(1, 12));
            gaps = 1'($urandom_range(0, 1));
            bad  = ($urandom_range(0, 3) == 0);
            build_frame(n, 1, bad);
            pulse_start();
            load_and_check("rand", gaps, 1'b0, 1'b0, 1'b0, 0);
        end

        chk("in_ready_low_during_write", rdy_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
